// File: rtl/ft2232_pkg.sv
`default_nettype none
// ============================================================================
// Package : ft2232_pkg
// Brief   : Shared types and constants for the FT2232H sync-FIFO chip model.
// Revision: 1.0 - initial release
// ============================================================================
package ft2232_pkg;

  typedef logic [7:0] byte_t;

  localparam int USB_HS_PKT_BYTES = 512;

  typedef enum logic [0:0] {
    PKT_COUNT = 1'b0,
    PKT_GAP   = 1'b1
  } pkt_state_t;

endpackage
`default_nettype wire

// File: rtl/ft2232_sync_fifo_model_if.sv
`default_nettype none
// ============================================================================
// Interface : ft2232_sync_fifo_model_if
// Brief     : FT2232H channel-A FIFO pins, host-side streams and status.
// Revision  : 1.0 - initial release
// ============================================================================
interface ft2232_sync_fifo_model_if;
  import ft2232_pkg::*;

  // FIFO pins (controller side)
  logic         rxf_n;
  logic         txe_n;
  logic         oe_n;
  logic         rd_n;
  logic         wr_n;
  logic         siwu;
  byte_t        data_in;
  byte_t        data_out;
  logic         data_oe;

  // Host side
  logic         host_tx_valid;
  byte_t        host_tx_data;
  logic         host_tx_ready;
  logic         host_rx_valid;
  byte_t        host_rx_data;
  logic         host_rx_ready;

  // Status
  logic         err_rd_wr;
  logic         err_contention;
  logic         err_underrun;
  logic [15:0]  tx_drop_cnt;

  modport master (
    output oe_n, rd_n, wr_n, siwu, data_in,
    output host_tx_valid, host_tx_data, host_rx_ready,
    input  rxf_n, txe_n, data_out, data_oe,
    input  host_tx_ready, host_rx_valid, host_rx_data,
    input  err_rd_wr, err_contention, err_underrun, tx_drop_cnt
  );

  modport slave (
    input  oe_n, rd_n, wr_n, siwu, data_in,
    input  host_tx_valid, host_tx_data, host_rx_ready,
    output rxf_n, txe_n, data_out, data_oe,
    output host_tx_ready, host_rx_valid, host_rx_data,
    output err_rd_wr, err_contention, err_underrun, tx_drop_cnt
  );

endinterface
`default_nettype wire

// File: rtl/ft2232_model_ring.sv
`default_nettype none
// ============================================================================
// Module  : ft2232_model_ring
// Brief   : Byte ring buffer with a registered head that already reflects this
//           edge's push/pop, so a reader popping every cycle streams bytes.
// Revision: 1.0 - initial release
// ============================================================================
module ft2232_model_ring
  import ft2232_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  byte_t               push_data,
  input  logic                pop,
  output byte_t               head,
  output logic [DEPTH_LOG2:0] count,
  output logic [DEPTH_LOG2:0] count_next
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] c_DEPTH   = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] c_CNT_ONE = (DEPTH_LOG2 + 1)'(1);

  byte_t                 r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  byte_t                 r_head;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push;
  logic [DEPTH_LOG2-1:0] w_rd_ptr_next;
  byte_t                 w_head_next;

  assign w_full  = (r_count == c_DEPTH);
  assign w_empty = (r_count == '0);
  assign w_pop   = pop & ~w_empty;
  // A full buffer still takes a byte when one leaves in the same cycle.
  assign w_push  = push & (~w_full | w_pop);

  always_comb begin
    w_rd_ptr_next = r_rd_ptr;
    count_next    = r_count;
    if (w_pop) begin
      w_rd_ptr_next = r_rd_ptr + DEPTH_LOG2'(1);
    end
    if (w_push && !w_pop) begin
      count_next = r_count + c_CNT_ONE;
    end else if (!w_push && w_pop) begin
      count_next = r_count - c_CNT_ONE;
    end
    w_head_next = r_mem[w_rd_ptr_next];
    if (count_next == '0) begin
      w_head_next = '0;
    end else if (w_push && (w_rd_ptr_next == r_wr_ptr)) begin
      w_head_next = push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
      end
      r_rd_ptr <= w_rd_ptr_next;
      r_count  <= count_next;
      r_head   <= w_head_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  assign head  = r_head;
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/ft2232_sync_fifo_model.sv
`default_nettype none
// ============================================================================
// Module  : ft2232_sync_fifo_model
// Brief   : FT2232HQ channel-A 245 synchronous-FIFO pin model with RX/TX
//           buffers, USB packet gaps on TXE# and sticky protocol error flags.
// Revision: 1.0 - initial release
// ============================================================================
module ft2232_sync_fifo_model
  import ft2232_pkg::*;
#(
  parameter int RX_DEPTH_LOG2 = 4,
  parameter int TX_DEPTH_LOG2 = 4,
  parameter int TX_PKT_BYTES  = USB_HS_PKT_BYTES,
  parameter int TX_PKT_GAP    = 8
) (
  input  logic                     fifo_clk_i,
  input  logic                     reset_i,
  ft2232_sync_fifo_model_if.slave  bus
);

  localparam logic [RX_DEPTH_LOG2:0] c_RX_DEPTH  = (RX_DEPTH_LOG2 + 1)'(1 << RX_DEPTH_LOG2);
  localparam logic [TX_DEPTH_LOG2:0] c_TX_DEPTH  = (TX_DEPTH_LOG2 + 1)'(1 << TX_DEPTH_LOG2);
  localparam logic [15:0]            c_PKT_BYTES = 16'(TX_PKT_BYTES);
  localparam logic [15:0]            c_GAP_LAST  = 16'(TX_PKT_GAP - 1);
  localparam logic                   c_PKT_ON    = (TX_PKT_BYTES != 0);
  localparam logic                   c_GAP_ON    = (TX_PKT_GAP != 0);

  logic                     r_rxf_n;
  logic                     r_txe_n;
  logic                     r_data_oe;
  logic                     r_alive;
  logic                     r_err_rd_wr;
  logic                     r_err_contention;
  logic                     r_err_underrun;
  logic [15:0]              r_drop_cnt;
  pkt_state_t               r_state;
  logic [15:0]              r_pkt_cnt;
  logic [15:0]              r_gap_cnt;

  pkt_state_t               w_state_next;
  logic [15:0]              w_pkt_cnt_next;
  logic [15:0]              w_gap_cnt_next;

  logic                     w_rd_wr;
  logic                     w_rx_push;
  logic                     w_rx_pop;
  logic                     w_tx_push;
  logic                     w_tx_pop;
  logic                     w_tx_drop;
  logic                     w_host_tx_ready;
  logic                     w_host_rx_valid;
  byte_t                    w_rx_head;
  byte_t                    w_tx_head;
  logic [RX_DEPTH_LOG2:0]   w_rx_count;
  logic [RX_DEPTH_LOG2:0]   w_rx_count_next;
  logic [TX_DEPTH_LOG2:0]   w_tx_count;
  logic [TX_DEPTH_LOG2:0]   w_tx_count_next;

  // Simultaneous RD#/WR# is illegal: neither side moves that cycle.
  assign w_rd_wr         = ~bus.rd_n & ~bus.wr_n;
  assign w_rx_pop        = ~bus.rd_n & ~bus.oe_n & ~r_rxf_n & ~w_rd_wr;
  assign w_tx_push       = ~bus.wr_n & ~r_txe_n & ~w_rd_wr;
  assign w_tx_drop       = ~bus.wr_n & r_txe_n;
  assign w_host_tx_ready = r_alive & (w_rx_count != c_RX_DEPTH);
  assign w_host_rx_valid = (w_tx_count != '0);
  assign w_rx_push       = bus.host_tx_valid & w_host_tx_ready;
  assign w_tx_pop        = w_host_rx_valid & bus.host_rx_ready;

  ft2232_model_ring #(
    .DEPTH_LOG2 (RX_DEPTH_LOG2)
  ) u_rx_ring (
    .clk        (fifo_clk_i),
    .rst        (reset_i),
    .push       (w_rx_push),
    .push_data  (bus.host_tx_data),
    .pop        (w_rx_pop),
    .head       (w_rx_head),
    .count      (w_rx_count),
    .count_next (w_rx_count_next)
  );

  ft2232_model_ring #(
    .DEPTH_LOG2 (TX_DEPTH_LOG2)
  ) u_tx_ring (
    .clk        (fifo_clk_i),
    .rst        (reset_i),
    .push       (w_tx_push),
    .push_data  (bus.data_in),
    .pop        (w_tx_pop),
    .head       (w_tx_head),
    .count      (w_tx_count),
    .count_next (w_tx_count_next)
  );

  always_comb begin
    w_state_next   = r_state;
    w_pkt_cnt_next = r_pkt_cnt;
    w_gap_cnt_next = r_gap_cnt;
    case (r_state)
      PKT_COUNT: begin
        if (w_tx_push) begin
          w_pkt_cnt_next = r_pkt_cnt + 16'd1;
        end
        // Full packet or send-immediate closes the current USB packet.
        if (c_GAP_ON && ((c_PKT_ON && w_tx_push && (w_pkt_cnt_next == c_PKT_BYTES)) || ~bus.siwu)) begin
          w_state_next   = PKT_GAP;
          w_pkt_cnt_next = '0;
          w_gap_cnt_next = '0;
        end
      end
      PKT_GAP: begin
        if (r_gap_cnt == c_GAP_LAST) begin
          w_state_next   = PKT_COUNT;
          w_gap_cnt_next = '0;
        end else begin
          w_gap_cnt_next = r_gap_cnt + 16'd1;
        end
      end
      default: begin
        w_state_next = PKT_COUNT;
      end
    endcase
  end

  always_ff @(posedge fifo_clk_i) begin
    if (reset_i) begin
      r_state   <= PKT_COUNT;
      r_pkt_cnt <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pkt_cnt <= w_pkt_cnt_next;
      r_gap_cnt <= w_gap_cnt_next;
    end
  end

  // Flags take the post-edge buffer state so the controller never overruns.
  always_ff @(posedge fifo_clk_i) begin
    if (reset_i) begin
      r_rxf_n          <= 1'b1;
      r_txe_n          <= 1'b1;
      r_data_oe        <= 1'b0;
      r_alive          <= 1'b0;
      r_err_rd_wr      <= 1'b0;
      r_err_contention <= 1'b0;
      r_err_underrun   <= 1'b0;
      r_drop_cnt       <= '0;
    end else begin
      r_rxf_n          <= (w_rx_count_next == '0);
      r_txe_n          <= (w_tx_count_next == c_TX_DEPTH) | (w_state_next == PKT_GAP);
      r_data_oe        <= ~bus.oe_n;
      r_alive          <= 1'b1;
      r_err_rd_wr      <= r_err_rd_wr | w_rd_wr;
      r_err_contention <= r_err_contention | (~bus.wr_n & ~bus.oe_n);
      r_err_underrun   <= r_err_underrun | (~bus.rd_n & ~bus.oe_n & r_rxf_n);
      if (w_tx_drop && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
    end
  end

  assign bus.rxf_n          = r_rxf_n;
  assign bus.txe_n          = r_txe_n;
  assign bus.data_out       = w_rx_head;
  assign bus.data_oe        = r_data_oe;
  assign bus.host_tx_ready  = w_host_tx_ready;
  assign bus.host_rx_valid  = w_host_rx_valid;
  assign bus.host_rx_data   = w_tx_head;
  assign bus.err_rd_wr      = r_err_rd_wr;
  assign bus.err_contention = r_err_contention;
  assign bus.err_underrun   = r_err_underrun;
  assign bus.tx_drop_cnt    = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ft2232_sync_fifo_model.sv
`default_nettype none
// ============================================================================
// Module  : tb_ft2232_sync_fifo_model
// Brief   : Scoreboard bench for the FT2232H sync-FIFO chip model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ft2232_sync_fifo_model;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] q[$];

  always #5 clk = ~clk;

  ft2232_sync_fifo_model_if bus ();
  ft2232_sync_fifo_model_if bus_pkt ();

  ft2232_sync_fifo_model #(
    .RX_DEPTH_LOG2 (4), .TX_DEPTH_LOG2 (4), .TX_PKT_BYTES (512), .TX_PKT_GAP (8)
  ) dut (
    .fifo_clk_i (clk), .reset_i (rst), .bus (bus.slave)
  );

  ft2232_sync_fifo_model #(
    .RX_DEPTH_LOG2 (4), .TX_DEPTH_LOG2 (4), .TX_PKT_BYTES (4), .TX_PKT_GAP (8)
  ) dut_pkt (
    .fifo_clk_i (clk), .reset_i (rst), .bus (bus_pkt.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    n_checks++; if (bus.rxf_n !== 1'b1) begin n_fail++; $display("FAIL reset_rxf_n: got %b expected 1", bus.rxf_n); end
    n_checks++; if (bus.txe_n !== 1'b1) begin n_fail++; $display("FAIL reset_txe_n: got %b expected 1", bus.txe_n); end
    n_checks++; if (bus.data_oe !== 1'b0) begin n_fail++; $display("FAIL reset_data_oe: got %b expected 0", bus.data_oe); end
    n_checks++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h expected 00", bus.data_out); end
    n_checks++; if (bus.host_tx_ready !== 1'b0) begin n_fail++; $display("FAIL reset_host_tx_ready: got %b expected 0", bus.host_tx_ready); end
    n_checks++; if (bus.host_rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_host_rx_valid: got %b expected 0", bus.host_rx_valid); end
    n_checks++; if ({bus.err_rd_wr, bus.err_contention, bus.err_underrun} !== 3'b000) begin
      n_fail++; $display("FAIL reset_errors: got %b expected 000", {bus.err_rd_wr, bus.err_contention, bus.err_underrun}); end
    n_checks++; if (bus.tx_drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop_cnt: got %0d expected 0", bus.tx_drop_cnt); end
    rst = 1'b0;
    tick();
    n_checks++; if (bus.txe_n !== 1'b0) begin n_fail++; $display("FAIL post_reset_txe_n: got %b expected 0", bus.txe_n); end
    n_checks++; if (bus.host_tx_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_host_tx_ready: got %b expected 1", bus.host_tx_ready); end
    n_checks++; if (bus.rxf_n !== 1'b1) begin n_fail++; $display("FAIL post_reset_rxf_n: got %b expected 1", bus.rxf_n); end
    n_checks++; if (bus_pkt.txe_n !== 1'b0) begin n_fail++; $display("FAIL post_reset_pkt_txe_n: got %b expected 0", bus_pkt.txe_n); end
  endtask

  task automatic test_rx_stream();
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) begin
      bus.host_tx_valid = 1'b1;
      bus.host_tx_data  = 8'(i);
      q.push_back(8'(i));
      tick();
    end
    bus.host_tx_valid = 1'b0;
    n_checks++; if (bus.host_tx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_full_ready: got %b expected 0", bus.host_tx_ready); end
    n_checks++; if (bus.rxf_n !== 1'b0) begin n_fail++; $display("FAIL rx_rxf_n_low: got %b expected 0", bus.rxf_n); end
    bus.oe_n = 1'b0;
    tick();
    n_checks++; if (bus.data_oe !== 1'b1) begin n_fail++; $display("FAIL rx_data_oe: got %b expected 1", bus.data_oe); end
    bus.rd_n = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp = q.pop_front();
      n_checks++; if (bus.data_out !== exp) begin n_fail++; $display("FAIL rx_stream_byte%0d: got %h expected %h", i, bus.data_out, exp); end
      tick();
    end
    bus.rd_n = 1'b1;
    n_checks++; if (bus.rxf_n !== 1'b1) begin n_fail++; $display("FAIL rx_rxf_n_empty: got %b expected 1", bus.rxf_n); end
    n_checks++; if (bus.err_underrun !== 1'b0) begin n_fail++; $display("FAIL rx_no_underrun: got %b expected 0", bus.err_underrun); end
    tick();
    bus.rd_n = 1'b0;
    tick();
    bus.rd_n = 1'b1;
    n_checks++; if (bus.err_underrun !== 1'b1) begin n_fail++; $display("FAIL rx_underrun: got %b expected 1", bus.err_underrun); end
    bus.oe_n = 1'b1;
    tick();
  endtask

  task automatic test_tx_overflow();
    logic [7:0] exp;
    int got;
    got = 0;
    bus.host_rx_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.wr_n    = 1'b0;
      bus.data_in = 8'hA0 + 8'(i);
      if (i < 16) q.push_back(8'hA0 + 8'(i));
      tick();
    end
    bus.wr_n = 1'b1;
    n_checks++; if (bus.txe_n !== 1'b1) begin n_fail++; $display("FAIL tx_full_txe_n: got %b expected 1", bus.txe_n); end
    n_checks++; if (bus.tx_drop_cnt !== 16'd4) begin n_fail++; $display("FAIL tx_drop_cnt: got %0d expected 4", bus.tx_drop_cnt); end
    n_checks++; if (bus.host_rx_valid !== 1'b1) begin n_fail++; $display("FAIL tx_host_valid: got %b expected 1", bus.host_rx_valid); end
    n_checks++; if (bus.err_contention !== 1'b0) begin n_fail++; $display("FAIL tx_no_contention: got %b expected 0", bus.err_contention); end
    bus.host_rx_ready = 1'b1;
    for (int c = 0; c < 40 && q.size() > 0; c++) begin
      if (bus.host_rx_valid) begin
        exp = q.pop_front();
        n_checks++; if (bus.host_rx_data !== exp) begin n_fail++; $display("FAIL tx_drain_byte%0d: got %h expected %h", got, bus.host_rx_data, exp); end
        got++;
      end
      tick();
    end
    bus.host_rx_ready = 1'b0;
    n_checks++; if (got !== 16) begin n_fail++; $display("FAIL tx_drain_count: got %0d expected 16", got); end
    n_checks++; if (bus.host_rx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_drained_valid: got %b expected 0", bus.host_rx_valid); end
    n_checks++; if (bus.txe_n !== 1'b0) begin n_fail++; $display("FAIL tx_drained_txe_n: got %b expected 0", bus.txe_n); end
    q.delete();
  endtask

  task automatic test_pkt_gap();
    logic [7:0] exp;
    int sent, rcv, gap_hi, early_hi;
    sent = 0; rcv = 0; gap_hi = 0; early_hi = 0;
    bus_pkt.host_rx_ready = 1'b1;
    for (int c = 0; c < 200 && (sent < 8 || q.size() > 0); c++) begin
      if (bus_pkt.host_rx_valid) begin
        if (q.size() == 0) begin
          n_checks++; n_fail++; $display("FAIL pkt_unexpected_byte: got %h expected none", bus_pkt.host_rx_data);
        end else begin
          exp = q.pop_front();
          n_checks++; if (bus_pkt.host_rx_data !== exp) begin n_fail++; $display("FAIL pkt_byte%0d: got %h expected %h", rcv, bus_pkt.host_rx_data, exp); end
        end
        rcv++;
      end
      if (sent < 4 && bus_pkt.txe_n) early_hi++;
      if (sent == 4 && bus_pkt.txe_n) gap_hi++;
      if (sent < 8 && !bus_pkt.txe_n) begin
        bus_pkt.wr_n    = 1'b0;
        bus_pkt.data_in = 8'h50 + 8'(sent);
        q.push_back(8'h50 + 8'(sent));
        sent++;
      end else begin
        bus_pkt.wr_n = 1'b1;
      end
      tick();
    end
    bus_pkt.wr_n = 1'b1;
    bus_pkt.host_rx_ready = 1'b0;
    n_checks++; if (early_hi !== 0) begin n_fail++; $display("FAIL pkt_early_txe_n: got %0d high cycles expected 0", early_hi); end
    n_checks++; if (gap_hi !== 8) begin n_fail++; $display("FAIL pkt_gap_len: got %0d expected 8", gap_hi); end
    n_checks++; if (sent !== 8) begin n_fail++; $display("FAIL pkt_sent: got %0d expected 8", sent); end
    n_checks++; if (rcv !== 8) begin n_fail++; $display("FAIL pkt_received: got %0d expected 8", rcv); end
    q.delete();
  endtask

  task automatic test_errors();
    logic [7:0] exp;
    for (int i = 0; i < 2; i++) begin
      bus.host_tx_valid = 1'b1;
      bus.host_tx_data  = 8'h11 * 8'(i + 1);
      q.push_back(8'h11 * 8'(i + 1));
      tick();
    end
    bus.host_tx_valid = 1'b0;
    bus.rd_n = 1'b0; bus.wr_n = 1'b0; bus.data_in = 8'h99;
    tick();
    bus.rd_n = 1'b1; bus.wr_n = 1'b1;
    n_checks++; if (bus.err_rd_wr !== 1'b1) begin n_fail++; $display("FAIL err_rd_wr: got %b expected 1", bus.err_rd_wr); end
    n_checks++; if (bus.host_rx_valid !== 1'b0) begin n_fail++; $display("FAIL rd_wr_no_push: got %b expected 0", bus.host_rx_valid); end
    n_checks++; if (bus.err_contention !== 1'b0) begin n_fail++; $display("FAIL rd_wr_no_contention: got %b expected 0", bus.err_contention); end
    bus.oe_n = 1'b0;
    tick();
    bus.rd_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp = q.pop_front();
      n_checks++; if (bus.data_out !== exp) begin n_fail++; $display("FAIL rd_wr_rx_byte%0d: got %h expected %h", i, bus.data_out, exp); end
      tick();
    end
    bus.rd_n = 1'b1;
    n_checks++; if (bus.rxf_n !== 1'b1) begin n_fail++; $display("FAIL rd_wr_rx_count: got rxf_n %b expected 1", bus.rxf_n); end
    bus.wr_n = 1'b0; bus.data_in = 8'h77;
    tick();
    bus.wr_n = 1'b1; bus.oe_n = 1'b1;
    n_checks++; if (bus.err_contention !== 1'b1) begin n_fail++; $display("FAIL err_contention: got %b expected 1", bus.err_contention); end
    bus.host_rx_ready = 1'b1;
    tick();
    bus.host_rx_ready = 1'b0;
  endtask

  task automatic test_siwu();
    int hi;
    hi = 0;
    n_checks++; if (bus.txe_n !== 1'b0) begin n_fail++; $display("FAIL siwu_pre_txe_n: got %b expected 0", bus.txe_n); end
    bus.siwu = 1'b0;
    tick();
    bus.siwu = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (bus.txe_n) hi++;
      tick();
    end
    n_checks++; if (hi !== 8) begin n_fail++; $display("FAIL siwu_gap_len: got %0d expected 8", hi); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      bus.host_tx_valid = 1'b1;
      bus.host_tx_data  = 8'hC0 + 8'(i);
      tick();
    end
    bus.oe_n = 1'b0;
    tick();
    n_checks++; if (bus.rxf_n !== 1'b0) begin n_fail++; $display("FAIL mid_pre_rxf_n: got %b expected 0", bus.rxf_n); end
    rst = 1'b1;
    tick();
    n_checks++; if (bus.rxf_n !== 1'b1) begin n_fail++; $display("FAIL mid_rst_rxf_n: got %b expected 1", bus.rxf_n); end
    n_checks++; if (bus.host_tx_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b expected 0", bus.host_tx_ready); end
    n_checks++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL mid_rst_data_out: got %h expected 00", bus.data_out); end
    n_checks++; if ({bus.err_rd_wr, bus.err_contention, bus.err_underrun} !== 3'b000) begin
      n_fail++; $display("FAIL mid_rst_errors: got %b expected 000", {bus.err_rd_wr, bus.err_contention, bus.err_underrun}); end
    bus.host_tx_valid = 1'b0;
    bus.oe_n = 1'b1;
    rst = 1'b0;
    tick();
    n_checks++; if (bus.rxf_n !== 1'b1) begin n_fail++; $display("FAIL mid_discarded_rxf_n: got %b expected 1", bus.rxf_n); end
    n_checks++; if (bus.host_tx_ready !== 1'b1) begin n_fail++; $display("FAIL mid_post_ready: got %b expected 1", bus.host_tx_ready); end
  endtask

  initial begin
    bus.oe_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b1; bus.siwu = 1'b1; bus.data_in = 8'h00;
    bus.host_tx_valid = 1'b0; bus.host_tx_data = 8'h00; bus.host_rx_ready = 1'b0;
    bus_pkt.oe_n = 1'b1; bus_pkt.rd_n = 1'b1; bus_pkt.wr_n = 1'b1; bus_pkt.siwu = 1'b1; bus_pkt.data_in = 8'h00;
    bus_pkt.host_tx_valid = 1'b0; bus_pkt.host_tx_data = 8'h00; bus_pkt.host_rx_ready = 1'b0;
    test_reset();
    test_rx_stream();
    test_tx_overflow();
    test_pkt_gap();
    test_errors();
    test_siwu();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
